// File: rtl/compress_pipe_ctrl_pkg.sv
// Shared definitions for the eight-word compression tree flow controller:
// FSM states, default widths and the tree's register depth.
package compress_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CPR_PIPE_DEPTH = 4;
  localparam int CPR_LEN_WIDTH  = 8;
  localparam int CPR_FLEN_WIDTH = 24;
  localparam int CPR_CNT_WIDTH  = 16;

endpackage

// File: rtl/compress_pipe_ctrl_valid_pipe.sv
// Valid/last shift register that rides alongside the tree registers and
// freezes together with them whenever the hold enable is low.
module valid_pipe
  import compress_pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = CPR_PIPE_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic v_in,
  input  logic l_in,
  output logic v_last,
  output logic l_last
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] l_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      l_q <= '0;
    end else if (en) begin
      v_q[0] <= v_in;
      l_q[0] <= l_in;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign v_last = v_q[DEPTH-1];
  assign l_last = l_q[DEPTH-1];

endmodule

// File: rtl/compress_pipe_ctrl.sv
// Flow controller for the compression tree: handshakes, frame FSM and frame
// length accumulation. Define CPR_CTRL_STATS_EN to build the stall counter.
module compress_pipe_ctrl
  import compress_pipe_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = CPR_PIPE_DEPTH,
  parameter int LEN_WIDTH  = CPR_LEN_WIDTH,
  parameter int FLEN_WIDTH = CPR_FLEN_WIDTH,
  parameter int CNT_WIDTH  = CPR_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wrtEn,
  input  logic [LEN_WIDTH-1:0]  tree_len,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic [FLEN_WIDTH-1:0] frame_len,
  output logic [CNT_WIDTH-1:0]  frame_blocks,
  output logic                  busy,
  output logic [31:0]           stat_stalls
);

  localparam int SUM_W = ((FLEN_WIDTH > LEN_WIDTH) ? FLEN_WIDTH : LEN_WIDTH) + 1;

  state_t state;
  state_t state_next;

  logic                  pipe_v;
  logic                  pipe_l;
  logic                  adv;
  logic                  accept;
  logic                  hs;
  logic [FLEN_WIDTH-1:0] acc_len;
  logic [CNT_WIDTH-1:0]  acc_blk;
  logic [SUM_W-1:0]      len_wide;
  logic [FLEN_WIDTH-1:0] len_sum;
  logic [CNT_WIDTH-1:0]  blk_sum;

  // A held output stalls every tree register at once; bubbles are never collapsed.
  assign adv       = ~pipe_v | out_ready;
  assign wrtEn     = adv;
  assign in_ready  = adv & (state != DRAIN);
  assign accept    = in_valid & in_ready;
  assign out_valid = pipe_v;
  assign out_last  = pipe_l & pipe_v;
  assign hs        = pipe_v & out_ready;
  assign busy      = (state != IDLE);

  valid_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_valid_pipe (
    .clk    (clk),
    .reset  (reset),
    .en     (adv),
    .v_in   (accept),
    .l_in   (in_last & accept),
    .v_last (pipe_v),
    .l_last (pipe_l)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = in_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept && in_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && out_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sum is formed one bit wider than either operand so overflow is visible for saturation.
  assign len_wide = SUM_W'(acc_len) + SUM_W'(tree_len);
  assign len_sum  = (len_wide > SUM_W'({FLEN_WIDTH{1'b1}})) ? {FLEN_WIDTH{1'b1}}
                                                             : len_wide[FLEN_WIDTH-1:0];
  assign blk_sum  = (&acc_blk) ? acc_blk : acc_blk + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_len      <= '0;
      acc_blk      <= '0;
      frame_len    <= '0;
      frame_blocks <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (hs) begin
        if (out_last) begin
          frame_len    <= len_sum;
          frame_blocks <= blk_sum;
          frame_done   <= 1'b1;
          acc_len      <= '0;
          acc_blk      <= '0;
        end else begin
          acc_len <= len_sum;
          acc_blk <= blk_sum;
        end
      end
    end
  end

`ifdef CPR_CTRL_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (pipe_v && !out_ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_stalls = stall_cnt;
`else
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_compress_pipe_ctrl.sv
// Directed self-checking bench for compress_pipe_ctrl; a second instance with
// an 8-bit frame accumulator exercises length saturation.
module tb_compress_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_last;
  logic [7:0]  tree_len;
  logic        out_ready;

  logic        in_ready;
  logic        wrt_en;
  logic        out_valid;
  logic        out_last;
  logic        frame_done;
  logic [23:0] frame_len;
  logic [15:0] frame_blocks;
  logic        busy;
  logic [31:0] stat_stalls;

  logic        s_in_ready;
  logic        s_wrt_en;
  logic        s_out_valid;
  logic        s_out_last;
  logic        s_frame_done;
  logic [7:0]  s_frame_len;
  logic [15:0] s_frame_blocks;
  logic        s_busy;
  logic [31:0] s_stat_stalls;

  int testsRun;
  int testsFailed;

  compress_pipe_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .wrtEn        (wrt_en),
    .tree_len     (tree_len),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .frame_blocks (frame_blocks),
    .busy         (busy),
    .stat_stalls  (stat_stalls)
  );

  compress_pipe_ctrl #(
    .FLEN_WIDTH (8)
  ) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (s_in_ready),
    .wrtEn        (s_wrt_en),
    .tree_len     (tree_len),
    .out_valid    (s_out_valid),
    .out_last     (s_out_last),
    .out_ready    (out_ready),
    .frame_done   (s_frame_done),
    .frame_len    (s_frame_len),
    .frame_blocks (s_frame_blocks),
    .busy         (s_busy),
    .stat_stalls  (s_stat_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic il, input logic ordy, input logic [7:0] tl);
    in_valid  = iv;
    in_last   = il;
    out_ready = ordy;
    tree_len  = tl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs, check the combinational handshake outputs, then advance.
  task automatic vec(input string tag, input logic iv, input logic il, input logic ordy,
                     input logic [7:0] tl, input logic e_ir, input logic e_ov, input logic e_ol);
    applyStimulus(iv, il, ordy, tl);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(e_ir));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    checkOutput({tag, ".out_last"}, 32'(out_last), 32'(e_ol));
    checkOutput({tag, ".wrtEn"}, 32'(wrt_en), 32'(!e_ov || ordy));
    tick();
  endtask

  task automatic checkFrame(input string tag, input logic [31:0] e_len, input logic [31:0] e_blk);
    checkOutput({tag, ".frame_done"}, 32'(frame_done), 32'd1);
    checkOutput({tag, ".frame_len"}, 32'(frame_len), e_len);
    checkOutput({tag, ".frame_blocks"}, 32'(frame_blocks), e_blk);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    out_ready   = 1'b1;
    tree_len    = 8'd0;
    #12;
    checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst.wrtEn", 32'(wrt_en), 32'd1);
    checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst.out_last", 32'(out_last), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst.frame_len", 32'(frame_len), 32'd0);
    checkOutput("rst.stat_stalls", 32'(stat_stalls), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Three-block frame, lengths 10/20/30, no backpressure.
    vec("f3.c0", 1, 0, 1, 0, 1, 0, 0);
    checkOutput("f3.busy", 32'(busy), 32'd1);
    vec("f3.c1", 1, 0, 1, 0, 1, 0, 0);
    vec("f3.c2", 1, 1, 1, 0, 1, 0, 0);
    vec("f3.c3", 0, 0, 1, 0, 0, 0, 0);
    vec("f3.c4", 0, 0, 1, 10, 0, 1, 0);
    vec("f3.c5", 0, 0, 1, 20, 0, 1, 0);
    vec("f3.c6", 0, 0, 1, 30, 0, 1, 1);
    checkFrame("f3", 32'd60, 32'd3);
    vec("f3.c7", 0, 0, 1, 0, 1, 0, 0);
    checkOutput("f3.pulse_end", 32'(frame_done), 32'd0);
    checkOutput("f3.len_held", 32'(frame_len), 32'd60);

    // Five-cycle stall with a full pipeline; lengths 1..6, stall-time value must be ignored.
    vec("st.c0", 1, 0, 1, 0, 1, 0, 0);
    vec("st.c1", 1, 0, 1, 0, 1, 0, 0);
    vec("st.c2", 1, 0, 1, 0, 1, 0, 0);
    vec("st.c3", 1, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      vec($sformatf("st.stall%0d", i), 1, 0, 0, 100, 0, 1, 0);
    end
    vec("st.c9", 1, 0, 1, 1, 1, 1, 0);
    vec("st.c10", 1, 1, 1, 2, 1, 1, 0);
    vec("st.c11", 0, 0, 1, 3, 0, 1, 0);
    vec("st.c12", 0, 0, 1, 4, 0, 1, 0);
    vec("st.c13", 0, 0, 1, 5, 0, 1, 0);
    vec("st.c14", 0, 0, 1, 6, 0, 1, 1);
    checkFrame("st", 32'd21, 32'd6);
`ifdef CPR_CTRL_STATS_EN
    checkOutput("st.stat_stalls", stat_stalls, 32'd5);
`else
    checkOutput("st.stat_stalls", stat_stalls, 32'd0);
`endif

    // Alternating in_valid; bubbles carry a junk length that must not be summed.
    vec("tg.c0", 1, 0, 1, 0, 1, 0, 0);
    vec("tg.c1", 0, 0, 1, 0, 1, 0, 0);
    vec("tg.c2", 1, 0, 1, 0, 1, 0, 0);
    vec("tg.c3", 0, 0, 1, 0, 1, 0, 0);
    vec("tg.c4", 1, 1, 1, 7, 1, 1, 0);
    vec("tg.c5", 0, 0, 1, 50, 0, 0, 0);
    vec("tg.c6", 0, 0, 1, 9, 0, 1, 0);
    vec("tg.c7", 0, 0, 1, 50, 0, 0, 0);
    vec("tg.c8", 0, 0, 1, 11, 0, 1, 1);
    checkFrame("tg", 32'd27, 32'd3);

    // Next frame held on the inputs while the previous one drains.
    vec("nx.c0", 1, 1, 1, 0, 1, 0, 0);
    vec("nx.c1", 1, 0, 1, 0, 0, 0, 0);
    vec("nx.c2", 1, 0, 1, 0, 0, 0, 0);
    vec("nx.c3", 1, 0, 1, 0, 0, 0, 0);
    vec("nx.c4", 1, 1, 1, 40, 0, 1, 1);
    checkFrame("nx.a", 32'd40, 32'd1);
    vec("nx.c5", 1, 1, 1, 0, 1, 0, 0);
    vec("nx.c6", 0, 0, 1, 0, 0, 0, 0);
    vec("nx.c7", 0, 0, 1, 0, 0, 0, 0);
    vec("nx.c8", 0, 0, 1, 0, 0, 0, 0);
    vec("nx.c9", 0, 0, 1, 5, 0, 1, 1);
    checkFrame("nx.b", 32'd5, 32'd1);

    // Eight blocks of length 255: wide accumulator sums, 8-bit one saturates.
    for (int i = 0; i < 8; i++) begin
      vec($sformatf("sat.in%0d", i), 1, (i == 7), 1, (i >= 4) ? 8'd255 : 8'd0, 1, (i >= 4), 0);
    end
    for (int i = 8; i < 12; i++) begin
      vec($sformatf("sat.out%0d", i), 0, 0, 1, 8'd255, 0, 1, (i == 11));
    end
    checkFrame("sat.wide", 32'd2040, 32'd8);
    checkOutput("sat.narrow.frame_done", 32'(s_frame_done), 32'd1);
    checkOutput("sat.narrow.frame_len", 32'(s_frame_len), 32'd255);
    checkOutput("sat.narrow.frame_blocks", 32'(s_frame_blocks), 32'd8);

    // Reset with two blocks in flight, then a clean single-block frame.
    vec("rf.c0", 1, 0, 1, 0, 1, 0, 0);
    vec("rf.c1", 1, 0, 1, 0, 1, 0, 0);
    vec("rf.c2", 0, 0, 1, 0, 1, 0, 0);
    checkOutput("rf.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #2;
    checkOutput("rf.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rf.busy", 32'(busy), 32'd0);
    checkOutput("rf.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rf.frame_len", 32'(frame_len), 32'd0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      vec($sformatf("rf.quiet%0d", i), 0, 0, 1, 0, 1, 0, 0);
      checkOutput("rf.no_done", 32'(frame_done), 32'd0);
    end
    vec("rf.n0", 1, 1, 1, 0, 1, 0, 0);
    vec("rf.n1", 0, 0, 1, 0, 0, 0, 0);
    vec("rf.n2", 0, 0, 1, 0, 0, 0, 0);
    vec("rf.n3", 0, 0, 1, 0, 0, 0, 0);
    vec("rf.n4", 0, 0, 1, 9, 0, 1, 1);
    checkFrame("rf", 32'd9, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
